// File: rtl/rambus_wb_master.sv
// Wishbone initiator for the OpenRAM rambus port B: valid/ready burst commands become single-beat classic cycles.
// Optional ack timeout is built only when RAMBUS_TIMEOUT_EN is defined.
module rambus_wb_master #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [7:0]  cmd_addr,
    input  logic [7:0]  cmd_len,
    input  logic        wdata_valid,
    output logic        wdata_ready,
    input  logic [31:0] wdata,
    output logic        rdata_valid,
    input  logic        rdata_ready,
    output logic [31:0] rdata,
    output logic        done,
    output logic        err,
    output logic        busy,
    output logic        rambus_wb_clk_o,
    output logic        rambus_wb_rst_o,
    output logic        rambus_wb_stb_o,
    output logic        rambus_wb_cyc_o,
    output logic        rambus_wb_we_o,
    output logic [3:0]  rambus_wb_sel_o,
    output logic [31:0] rambus_wb_dat_o,
    output logic [9:0]  rambus_wb_adr_o,
    input  logic        rambus_wb_ack_i,
    input  logic [31:0] rambus_wb_dat_i
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WDATA = 2'd1,
        BUS   = 2'd2,
        RDATA = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_cmd_ready;
    logic        r_we;
    logic        r_stb;
    logic        r_done;
    logic [7:0]  r_addr;
    logic [7:0]  r_rem;
    logic [31:0] r_dat_o;
    logic [31:0] r_rdata;

`ifdef RAMBUS_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] r_tcnt;
    logic       r_err;
`endif

    // cmd_ready is a flop rather than a state decode so that it reads 0 while reset is held
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state     <= IDLE;
            r_cmd_ready <= 1'b0;
            r_we        <= 1'b0;
            r_stb       <= 1'b0;
            r_done      <= 1'b0;
            r_addr      <= '0;
            r_rem       <= '0;
            r_dat_o     <= '0;
            r_rdata     <= '0;
`ifdef RAMBUS_TIMEOUT_EN
            r_tcnt      <= '0;
            r_err       <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
`ifdef RAMBUS_TIMEOUT_EN
            r_err  <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (cmd_valid && r_cmd_ready) begin
                        r_we        <= cmd_we;
                        r_addr      <= cmd_addr;
                        r_rem       <= cmd_len;
                        r_cmd_ready <= 1'b0;
`ifdef RAMBUS_TIMEOUT_EN
                        r_tcnt      <= '0;
`endif
                        if (cmd_we) begin
                            r_state <= WDATA;
                        end else begin
                            r_state <= BUS;
                            r_stb   <= 1'b1;
                        end
                    end else begin
                        r_cmd_ready <= 1'b1;
                    end
                end
                WDATA: begin
                    if (wdata_valid) begin
                        r_dat_o <= wdata;
                        r_state <= BUS;
                        r_stb   <= 1'b1;
`ifdef RAMBUS_TIMEOUT_EN
                        r_tcnt  <= '0;
`endif
                    end
                end
                BUS: begin
                    if (rambus_wb_ack_i) begin
                        r_stb <= 1'b0;
                        if (!r_we) begin
                            r_rdata <= rambus_wb_dat_i;
                            r_state <= RDATA;
                        end else if (r_rem == 8'd0) begin
                            r_state     <= IDLE;
                            r_done      <= 1'b1;
                            r_cmd_ready <= 1'b1;
                        end else begin
                            r_addr  <= r_addr + 8'd1;
                            r_rem   <= r_rem - 8'd1;
                            r_state <= WDATA;
                        end
                    end
`ifdef RAMBUS_TIMEOUT_EN
                    else if (r_tcnt == TMO_LAST) begin
                        r_stb       <= 1'b0;
                        r_state     <= IDLE;
                        r_done      <= 1'b1;
                        r_err       <= 1'b1;
                        r_cmd_ready <= 1'b1;
                    end else begin
                        r_tcnt <= r_tcnt + 8'd1;
                    end
`endif
                end
                RDATA: begin
                    if (rdata_ready) begin
                        if (r_rem == 8'd0) begin
                            r_state     <= IDLE;
                            r_done      <= 1'b1;
                            r_cmd_ready <= 1'b1;
                        end else begin
                            r_addr  <= r_addr + 8'd1;
                            r_rem   <= r_rem - 8'd1;
                            r_state <= BUS;
                            r_stb   <= 1'b1;
`ifdef RAMBUS_TIMEOUT_EN
                            r_tcnt  <= '0;
`endif
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign cmd_ready       = r_cmd_ready;
    assign wdata_ready     = (r_state == WDATA);
    assign rdata_valid     = (r_state == RDATA);
    assign busy            = (r_state != IDLE);
    assign rdata           = r_rdata;
    assign done            = r_done;
`ifdef RAMBUS_TIMEOUT_EN
    assign err             = r_err;
`else
    assign err             = 1'b0;
`endif
    assign rambus_wb_clk_o = wb_clk_i;
    assign rambus_wb_rst_o = ~wb_rst_ni;
    assign rambus_wb_stb_o = r_stb;
    assign rambus_wb_cyc_o = r_stb;
    assign rambus_wb_we_o  = r_we;
    assign rambus_wb_sel_o = 4'hF;
    assign rambus_wb_dat_o = r_dat_o;
    assign rambus_wb_adr_o = {r_addr, 2'b00};

endmodule
